// File: rtl/psum_collector.sv
// Column-bottom collector: packs partial-sum results into wide words,
// tags them with keep/last and queues them in a FWFT FIFO for write-back.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   O_DataIn, O_NOPIn   result and its valid strobe from the last PE
//   O_DataInRdy         throttle hint to the last PE (skid reserve kept free)
//   Flush               pulse: close the pending partial word as a row end
//   Out_Data/Keep/Last  FIFO head word, lane mask and row-end flag
//   Out_Valid, Out_Rdy  write-back handshake
//   Overflow            sticky word-drop indicator
//   RowCount            rows completed since reset (wraps)
module psum_collector #(
    parameter int DataInWidth = 8,
    parameter int PackFactor  = 4,
    parameter int FifoDepth   = 16,
    parameter int SkidReserve = 3,
    parameter int RowLen      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DataInWidth-1:0]            O_DataIn,
    input  logic                              O_NOPIn,
    output logic                              O_DataInRdy,
    input  logic                              Flush,
    output logic [DataInWidth*PackFactor-1:0] Out_Data,
    output logic [PackFactor-1:0]             Out_Keep,
    output logic                              Out_Last,
    output logic                              Out_Valid,
    input  logic                              Out_Rdy,
    output logic                              Overflow,
    output logic [15:0]                       RowCount
);

    localparam int WW = DataInWidth * PackFactor;
    localparam int LW = $clog2(PackFactor);
    localparam int PW = $clog2(FifoDepth);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(RowLen) + 1;

    logic [LW-1:0] lane_cnt;
    logic [RW-1:0] row_cnt;
    logic [WW-1:0] pack_data;
    logic [PackFactor-1:0] pack_keep;

    logic [WW-1:0] cap_data;
    logic [PackFactor-1:0] cap_keep;
    logic full_close, row_close, flush_close;
    logic push, row_end;

    logic [WW-1:0] mem_data [FifoDepth];
    logic [PackFactor-1:0] mem_keep [FifoDepth];
    logic mem_last [FifoDepth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic pop, push_ok;

    // Word being closed this cycle: pack register plus any same-cycle capture.
    always_comb begin
        cap_data = pack_data;
        cap_keep = pack_keep;
        if (O_NOPIn) begin
            cap_data[int'(lane_cnt)*DataInWidth +: DataInWidth] = O_DataIn;
            cap_keep[lane_cnt] = 1'b1;
        end
    end

    assign full_close  = O_NOPIn && (lane_cnt == LW'(PackFactor - 1));
    assign row_close   = O_NOPIn && (row_cnt == RW'(RowLen - 1));
    assign flush_close = Flush && ((lane_cnt != '0) || O_NOPIn);
    assign push        = full_close || row_close || flush_close;
    assign row_end     = row_close || flush_close;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt  <= '0;
            row_cnt   <= '0;
            pack_data <= '0;
            pack_keep <= '0;
            RowCount  <= '0;
        end else begin
            if (push) begin
                lane_cnt  <= '0;
                pack_data <= '0;
                pack_keep <= '0;
            end else if (O_NOPIn) begin
                lane_cnt  <= lane_cnt + LW'(1);
                pack_data <= cap_data;
                pack_keep <= cap_keep;
            end
            if (row_end) begin
                row_cnt  <= '0;
                RowCount <= RowCount + 16'd1;
            end else if (O_NOPIn) begin
                row_cnt <= row_cnt + RW'(1);
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop     = (count != '0) && Out_Rdy;
    assign push_ok = push && ((count != CW'(FifoDepth)) || pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (!push_ok && pop)
                count <= count - CW'(1);
            if (push && !push_ok)
                Overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= cap_data;
            mem_keep[wr_ptr] <= cap_keep;
            mem_last[wr_ptr] <= row_end;
        end
    end

    // Head is gated so unwritten storage never shows on the bus.
    assign Out_Valid = (count != '0);
    assign Out_Data  = Out_Valid ? mem_data[rd_ptr] : '0;
    assign Out_Keep  = Out_Valid ? mem_keep[rd_ptr] : '0;
    assign Out_Last  = Out_Valid ? mem_last[rd_ptr] : 1'b0;

    assign O_DataInRdy = (CW'(FifoDepth) - count) >= CW'(SkidReserve);

endmodule

// File: tb/tb_psum_collector.sv
// Randomized and directed bench for psum_collector with a queue-based
// reference model of packing, row ends and the output FIFO.
module tb_psum_collector;

    localparam int DW = 8;
    localparam int PF = 4;
    localparam int FD = 16;
    localparam int SR = 3;
    localparam int RL = 6;

    logic clk = 1'b0;
    logic reset;
    logic [DW-1:0] O_DataIn;
    logic O_NOPIn;
    logic O_DataInRdy;
    logic Flush;
    logic [DW*PF-1:0] Out_Data;
    logic [PF-1:0] Out_Keep;
    logic Out_Last;
    logic Out_Valid;
    logic Out_Rdy;
    logic Overflow;
    logic [15:0] RowCount;

    psum_collector #(
        .DataInWidth(DW), .PackFactor(PF), .FifoDepth(FD),
        .SkidReserve(SR), .RowLen(RL)
    ) dut (
        .clk(clk), .reset(reset),
        .O_DataIn(O_DataIn), .O_NOPIn(O_NOPIn), .O_DataInRdy(O_DataInRdy),
        .Flush(Flush),
        .Out_Data(Out_Data), .Out_Keep(Out_Keep), .Out_Last(Out_Last),
        .Out_Valid(Out_Valid), .Out_Rdy(Out_Rdy),
        .Overflow(Overflow), .RowCount(RowCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] cur[$];
    int row_n;
    word_t mq[$];
    bit m_ovf;
    logic [15:0] m_rows;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        mq.delete();
        row_n = 0;
        m_ovf = 0;
        m_rows = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input bit nop, input logic [7:0] d, input bit fl, input bit rdy);
        int sz;
        bit pop, close, last;
        word_t w;
        sz = mq.size();
        pop = (sz != 0) && rdy;
        last = 0;
        if (nop) begin
            cur.push_back(d);
            row_n++;
        end
        close = (cur.size() == PF) || (row_n == RL && nop) || (fl && cur.size() > 0);
        if (close) begin
            last = (row_n == RL && nop) || fl;
            w.d = '0;
            foreach (cur[i]) w.d = w.d | (32'(cur[i]) << (8 * i));
            w.k = 4'((1 << cur.size()) - 1);
            w.l = last;
            cur.delete();
            if (last) begin
                row_n = 0;
                m_rows = m_rows + 16'd1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (close) begin
            if (sz < FD || pop) mq.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic compare();
        chk("valid", Out_Valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("data", Out_Data, mq[0].d);
            chk("keep", Out_Keep, mq[0].k);
            chk("last", Out_Last, mq[0].l);
        end else begin
            chk("idle_data", {Out_Data, Out_Keep, Out_Last}, 0);
        end
        chk("overflow", Overflow, m_ovf);
        chk("rowcount", RowCount, m_rows);
        chk("in_rdy", O_DataInRdy, (FD - mq.size()) >= SR);
    endtask

    task automatic step(input bit nop, input logic [7:0] d, input bit fl, input bit rdy);
        O_NOPIn = nop;
        O_DataIn = d;
        Flush = fl;
        Out_Rdy = rdy;
        @(posedge clk);
        model_edge(nop, d, fl, rdy);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        O_NOPIn = 0;
        O_DataIn = 0;
        Flush = 0;
        Out_Rdy = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare();
        reset = 1'b1;
        step(0, 0, 0, 0);
    endtask

    int thresh;

    initial begin
        reset = 1'b0;
        O_NOPIn = 0;
        O_DataIn = 0;
        Flush = 0;
        Out_Rdy = 0;
        @(negedge clk);

        // Reset values
        do_reset();
        chk("rst_valid", Out_Valid, 0);
        chk("rst_rdy", O_DataInRdy, 1);
        chk("rst_ovf", Overflow, 0);
        chk("rst_rows", RowCount, 0);

        // Pack four results
        step(1, 8'h11, 0, 1);
        step(1, 8'h22, 0, 1);
        step(1, 8'h33, 0, 1);
        chk("pack_not_yet", Out_Valid, 0);
        step(1, 8'h44, 0, 1);
        chk("pack_valid", Out_Valid, 1);
        chk("pack_data", Out_Data, 32'h44332211);
        chk("pack_keep", Out_Keep, 4'hF);
        chk("pack_last", Out_Last, 0);
        step(0, 0, 0, 1);
        chk("pack_drained", Out_Valid, 0);

        // Row end with a partial word
        do_reset();
        for (int i = 1; i <= 6; i++) step(1, 8'(i), 0, 0);
        chk("row_w0", Out_Data, 32'h04030201);
        chk("row_k0", Out_Keep, 4'hF);
        chk("row_l0", Out_Last, 0);
        chk("row_cnt", RowCount, 1);
        step(0, 0, 0, 1);
        chk("row_w1", Out_Data, 32'h00000605);
        chk("row_k1", Out_Keep, 4'h3);
        chk("row_l1", Out_Last, 1);

        // Flush
        do_reset();
        step(1, 8'hAA, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("fl_data", Out_Data, 32'h000000AA);
        chk("fl_keep", Out_Keep, 4'h1);
        chk("fl_last", Out_Last, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("fl_empty", Out_Valid, 0);
        chk("fl_rows", RowCount, 1);

        // Backpressure and skid reserve
        do_reset();
        for (int i = 0; i < 41; i++) step(1, 8'($urandom), 0, 0);
        chk("bp_rdy_13", O_DataInRdy, 1);
        step(1, 8'($urandom), 0, 0);
        chk("bp_rdy_14", O_DataInRdy, 0);
        for (int i = 0; i < 7; i++) step(1, 8'($urandom), 0, 0);
        chk("bp_no_ovf", Overflow, 0);

        // Overflow: the 17th word is dropped, the first 16 survive
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0, 0);
        chk("ovf_set", Overflow, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        chk("ovf_drained", Out_Valid, 0);
        chk("ovf_sticky", Overflow, 1);

        // Push and pop together on a full FIFO
        do_reset();
        for (int i = 0; i < 48; i++) step(1, 8'($urandom), 0, 0);
        step(1, 8'h55, 1, 1);
        chk("full_pp_ovf", Overflow, 0);
        chk("full_pp_rdy", O_DataInRdy, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);

        // Random traffic with occasional mid-run reset
        thresh = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) thresh = $urandom_range(10, 100);
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 9) < 6, 8'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) < thresh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
